// File: rtl/led_fade_pwm_if.sv
// led_fade_pwm_if
//   Command channel into the LED fader.
//   cmd_valid  master->slave  command present
//   cmd_ready  slave->master  command accepted when cmd_valid && cmd_ready
//   cmd_chan   master->slave  0=R 1=G 2=B 3=all three
//   cmd_level  master->slave  target duty 0..255
interface led_fade_pwm_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_chan;
    logic [7:0] cmd_level;

    modport master (
        output cmd_valid,
        output cmd_chan,
        output cmd_level,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_chan,
        input  cmd_level,
        output cmd_ready
    );
endinterface

// File: rtl/led_fade_pwm.sv
// led_fade_pwm
//   Drives three LED pins with 8-bit PWM. Each channel's duty ramps one step
//   toward its commanded target every FADE_DIV PWM periods, so colour changes
//   fade smoothly instead of jumping.
// Ports
//   clk     system clock
//   rst     synchronous reset, active high
//   cmd     command channel (slave side): valid/ready, channel select, level
//   busy    high while any channel is still fading
//   LED_R   PWM output, red
//   LED_G   PWM output, green
//   LED_B   PWM output, blue
// Parameters
//   CLK_DIV      prescaler terminal count; one PWM tick every CLK_DIV+1 clk
//   FADE_DIV     PWM periods per fade step (>=1)
//   ACTIVE_HIGH  1: LED on drives 1; 0: LED on drives 0
module led_fade_pwm #(
    parameter int CLK_DIV     = 195,
    parameter int FADE_DIV    = 4,
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    led_fade_pwm_if.slave cmd,
    output logic          busy,
    output logic          LED_R,
    output logic          LED_G,
    output logic          LED_B
);

    localparam int   PRE_W   = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
    localparam int   FADE_W  = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic LED_OFF = ~ACTIVE_HIGH;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FADE = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_busy;
    logic              r_ready;
    logic [PRE_W-1:0]  r_prescaler;
    logic [7:0]        r_pwm_cnt;
    logic [FADE_W-1:0] r_fade_cnt;
    logic [2:0][7:0]   r_duty;
    logic [2:0][7:0]   r_target;
    logic [2:0]        r_led;

    logic              w_tick;
    logic              w_period_end;
    logic              w_accept;
    logic              w_fade_last;
    logic              w_step;
    logic [2:0]        w_sel;
    logic [2:0]        w_on;
    logic [2:0]        w_neq;
    logic [2:0][7:0]   w_target_next;
    logic [2:0][7:0]   w_duty_step;
    logic [2:0][7:0]   w_duty_next;

    assign w_tick       = (r_prescaler == PRE_W'(CLK_DIV));
    assign w_period_end = w_tick && (r_pwm_cnt == 8'hFF);
    assign w_accept     = cmd.cmd_valid && r_ready;
    assign w_fade_last  = (r_fade_cnt == FADE_W'(FADE_DIV - 1));
    // Duty only moves on a period boundary, so a PWM period never sees
    // two different duty values.
    assign w_step       = (r_state == S_FADE) && w_period_end && w_fade_last;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            assign w_sel[gi] = w_accept &&
                               ((cmd.cmd_chan == 2'd3) || (cmd.cmd_chan == 2'(gi)));

            assign w_target_next[gi] = w_sel[gi] ? cmd.cmd_level : r_target[gi];

            // Step toward the target held before this edge; a command landing
            // on the same edge only influences the following step. Stopping at
            // the target means duty can never wrap past 0 or 255.
            assign w_duty_step[gi] = (r_duty[gi] < r_target[gi]) ? r_duty[gi] + 8'd1 :
                                     (r_duty[gi] > r_target[gi]) ? r_duty[gi] - 8'd1 :
                                                                   r_duty[gi];

            assign w_duty_next[gi] = w_step ? w_duty_step[gi] : r_duty[gi];

            // Fading is finished once every channel sits on its (new) target.
            assign w_neq[gi] = (w_duty_next[gi] != w_target_next[gi]);

            // 255 is forced solid; pwm_cnt never exceeds 255 so the compare
            // alone would leave one dark tick per period.
            assign w_on[gi] = (r_duty[gi] == 8'hFF) || (r_pwm_cnt < r_duty[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty   <= '0;
            r_target <= '0;
            r_led    <= {3{LED_OFF}};
        end else begin
            r_duty   <= w_duty_next;
            r_target <= w_target_next;
            r_led    <= w_on ^ {3{LED_OFF}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_ready     <= 1'b0;
            r_prescaler <= '0;
            r_pwm_cnt   <= '0;
            r_fade_cnt  <= '0;
        end else begin
            r_ready <= 1'b1;

            if (w_tick) begin
                r_prescaler <= '0;
                r_pwm_cnt   <= r_pwm_cnt + 8'd1;
            end else begin
                r_prescaler <= r_prescaler + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    // Held at zero so a fade always starts with a full
                    // FADE_DIV-period wait before its first step.
                    r_fade_cnt <= '0;
                    if (|w_neq) begin
                        r_state <= S_FADE;
                        r_busy  <= 1'b1;
                    end
                end
                S_FADE: begin
                    if (w_period_end) begin
                        r_fade_cnt <= w_fade_last ? '0 : r_fade_cnt + 1'b1;
                    end
                    // Covers both a final step and a retarget onto the
                    // current duty values.
                    if (~|w_neq) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd.cmd_ready = r_ready;
    assign busy          = r_busy;
    assign LED_R         = r_led[0];
    assign LED_G         = r_led[1];
    assign LED_B         = r_led[2];

endmodule
